mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT_CYC, 255, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 There SHALL be one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 if_req  in  1  fetch request; it is held with if_addr stable until if_gnt.
REQ-006 if_addr  in  ADDR_W  fetch address.
REQ-007 if_gnt / if_rvalid  out  1 each  fetch accepted / fetch data valid.
REQ-008 if_rdata  out  DATA_W  fetch data.
REQ-009 d_req, d_we  in  1 each  data request and write-enable; held with address and write data until d_gnt.
REQ-010 d_addr / d_wdata  in  ADDR_W / DATA_W  data address and write data.
REQ-011 d_gnt / d_rvalid  out  1 each  data accepted / load data valid.
REQ-012 d_rdata  out  DATA_W  load data.
REQ-013 m_req, m_we  out  1 each  memory request and write-enable.
REQ-014 m_addr / m_wdata  out  ADDR_W / DATA_W  registered memory address and write data.
REQ-015 m_ready / m_rvalid  in  1 each  memory accept / read data valid.
REQ-016 m_rdata  in  DATA_W  memory read data.
REQ-017 err  out  1  sticky timeout flag.

Function
REQ-018 The block SHALL share one single-ported memory between the fetch and data requesters, with at most one transaction outstanding.
REQ-019 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-020 IDLE: when any req is high, the block SHALL latch owner, address, write data and we into m_* registers and go to REQ on the next edge; there is no combinational req-to-m_req path.
REQ-021 Arbitration SHALL be round-robin via a last_owner bit: on a tie the requester not served last wins; a lone requester always wins.
REQ-022 REQ: m_req SHALL be 1 and m_* stable until m_ready; in the m_ready cycle the owner's gnt SHALL pulse for 1 cycle.
REQ-023 From REQ on m_ready, a write SHALL go to IDLE; a read SHALL go to RESP.
REQ-024 RESP: m_rvalid and m_rdata SHALL be routed combinationally to the owner's rvalid/rdata; on m_rvalid the FSM SHALL go to IDLE and update last_owner.
REQ-025 The non-owner's gnt and rvalid SHALL stay 0; rdata outputs SHALL be m_rdata, qualified only by rvalid.
REQ-026 m_rvalid seen in IDLE or REQ SHALL be ignored.
REQ-027 A write through the fetch port is impossible: m_we SHALL be 0 for fetch ownership.
REQ-028 Back-to-back: if m_rvalid arrives in the same cycle as a new req, that req SHALL be arbitrated in the following IDLE cycle, giving minimum read occupancy of 3 cycles (IDLE, REQ, RESP).
REQ-029 A requester dropping req before gnt is illegal; behaviour is unspecified.

Reset
REQ-030 On rst the block SHALL go to IDLE with last_owner=data, so fetch wins the first tie.
REQ-031 On rst, m_req, m_we, m_addr, m_wdata, every gnt/rvalid and err SHALL be 0.
REQ-032 Reset mid-transaction SHALL abandon it; a late m_rvalid SHALL be dropped per REQ-026.

Configuration
REQ-033 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ/RESP and count each cycle in those states.
REQ-034 With MEM_ARB_TIMEOUT_EN, reaching TIMEOUT_CYC SHALL force IDLE, set err (sticky until rst) and pulse no gnt/rvalid.
REQ-035 Macro MEM_ARB_TIMEOUT_EN undefined: no counter is built, err SHALL be tied 0, and the FSM SHALL wait indefinitely.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE/REQ/RESP), the owner encoding (OWN_IF=0, OWN_D=1) and the default widths.
REQ-037 The round-robin pick SHALL be one sub-module, rr_pick2 (req[1:0], last -> sel); everything else is flat.

Verification
REQ-038 Fetch read: if_req=1, if_addr=0x10; m_ready on the first REQ cycle; m_rvalid=1 with m_rdata=0x00A00093 two cycles later -> if_gnt 1 pulse, then if_rvalid=1 with if_rdata=0x00A00093, d_* silent.
REQ-039 Data write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, m_ready delayed 3 cycles -> m_* stable through stalls, d_gnt on the m_ready cycle, return to IDLE without RESP.
REQ-040 Tie: if_req and d_req held high for 4 transactions after reset -> grant order IF, D, IF, D.
REQ-041 Reset mid-RESP: assert rst, then inject m_rvalid=1 -> no rvalid on either port, state IDLE, m_req=0.
REQ-042 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, m_ready held 0 -> at cycle 8 err=1 and FSM in IDLE; err stays 1 until rst.
REQ-043 Without MEM_ARB_TIMEOUT_EN, same stimulus for 1000 cycles -> err=0 and m_req still 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the memory port arbiter.
// FSM state encoding, owner encoding and default bus widths live here so the
// top and the round-robin picker agree on them.
package mem_port_arbiter_pkg;

    // Default widths and watchdog limit
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Owner encoding: bit index into the {d_req, if_req} request vector
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick.
// req[0] is the fetch port, req[1] the data port. A lone requester always
// wins; on a tie the requester that was not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);

    // Tie goes to the side not served last; otherwise req[1] alone picks data
    assign sel = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between a fetch port and
// a data port, one transaction in flight at a time (IDLE -> REQ -> [RESP]).
// All m_* request fields come from registers latched in IDLE, so there is no
// combinational path from a requester to the memory request.
// Optional feature: define MEM_ARB_TIMEOUT_EN to build a watchdog that
// abandons a transaction after TIMEOUT_CYC cycles in REQ/RESP and sets a
// sticky err flag. Without it err is tied low and the FSM waits forever.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    // status
    output logic              err
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_sel;
    logic              w_any_req;
    logic              w_tmo;
    logic              w_gnt;
    logic              w_rvld;

    assign w_any_req = if_req | d_req;

    rr_pick2 u_rr_pick2 (
        .req  ({d_req, if_req}),
        .last (r_last),
        .sel  (w_sel)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Watchdog: restart on every state change, count while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Last busy cycle before the limit forces the FSM back to IDLE
    assign w_tmo = (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // Watchdog limit has no meaning without the timeout feature
    localparam int TMO_UNUSED = TIMEOUT_CYC;

    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a timeout overrides any handshake in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_state_nxt = REQ;
            end
            REQ: begin
                if (w_tmo)        w_state_nxt = IDLE;
                else if (m_ready) w_state_nxt = r_we ? IDLE : RESP;
            end
            RESP: begin
                if (w_tmo)         w_state_nxt = IDLE;
                else if (m_rvalid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: memory request, owner-steered grant and read-valid
    always_comb begin
        m_req     = (r_state == REQ);
        w_gnt     = (r_state == REQ)  && m_ready  && !w_tmo;
        w_rvld    = (r_state == RESP) && m_rvalid && !w_tmo;
        if_gnt    = w_gnt  && (r_owner == OWN_IF);
        d_gnt     = w_gnt  && (r_owner == OWN_D);
        if_rvalid = w_rvld && (r_owner == OWN_IF);
        d_rvalid  = w_rvld && (r_owner == OWN_D);
    end

    // Read data goes to both ports; rvalid alone qualifies it
    assign if_rdata = m_rdata;
    assign d_rdata  = m_rdata;

    assign m_we    = r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    // Request capture in IDLE and round-robin history update on grant.
    // last_owner moves at the grant: arbitration only happens in IDLE, so this
    // is indistinguishable from updating at read completion, and it also
    // covers writes which never visit RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_IF;
            r_last  <= OWN_D;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if ((r_state == IDLE) && w_any_req) begin
                r_owner <= w_sel;
                if (w_sel == OWN_D) begin
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                    r_we    <= d_we;
                end else begin
                    // fetch port is read-only
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                    r_we    <= 1'b0;
                end
            end
            if (w_gnt) begin
                r_last <= r_owner;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table of transactions applied back-to-back, with a
// scoreboard of expected memory requests and read data, plus hand-written
// sequences for reset mid-transaction and the watchdog.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        m_req, m_we, m_ready, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err(err)
    );

    typedef struct {
        logic        ifr, dr, dwe;
        logic [31:0] ia, da, dwd, rd;
        int          rdly, vdly;
        logic        own;
    } vec_t;

    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    vec_t        tbl[8];
    txn_t        sb_q[$];
    logic [31:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction starting in an IDLE cycle; returns in the next IDLE cycle
    task automatic run_vec(input vec_t v);
        txn_t        t;
        txn_t        p;
        logic [31:0] erd;
        if_req  = v.ifr;  d_req  = v.dr;  d_we    = v.dwe;
        if_addr = v.ia;   d_addr = v.da;  d_wdata = v.dwd;
        t.own   = v.own;
        t.addr  = (v.own == OWN_D) ? v.da : v.ia;
        t.we    = (v.own == OWN_D) ? v.dwe : 1'b0;
        t.wdata = v.dwd;
        sb_q.push_back(t);
        @(negedge clk);
        chk("idle_mreq", 32'(m_req), 32'd0);
        tick();
        // memory stalls; a stray m_rvalid here must be ignored
        for (int s = 0; s < v.rdly; s++) begin
            m_ready = 1'b0; m_rvalid = 1'b1;
            @(negedge clk);
            chk("stall_mreq", 32'(m_req), 32'd1);
            chk("stall_addr", m_addr, t.addr);
            chk("stall_gnt", 32'({d_gnt, if_gnt}), 32'd0);
            chk("stall_rvalid", 32'({d_rvalid, if_rvalid}), 32'd0);
            tick();
        end
        m_ready = 1'b1; m_rvalid = 1'b0;
        @(negedge clk);
        chk("gnt", 32'({d_gnt, if_gnt}), (v.own == OWN_D) ? 32'd2 : 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            p = sb_q.pop_front();
            chk("m_addr", m_addr, p.addr);
            chk("m_we", 32'(m_we), 32'(p.we));
            if (p.we) chk("m_wdata", m_wdata, p.wdata);
        end
        tick();
        m_ready = 1'b0;
        if (!t.we) begin
            for (int s = 0; s < v.vdly; s++) begin
                @(negedge clk);
                chk("resp_wait_rvalid", 32'({d_rvalid, if_rvalid}), 32'd0);
                chk("resp_mreq", 32'(m_req), 32'd0);
                tick();
            end
            m_rvalid = 1'b1; m_rdata = v.rd;
            rd_q.push_back(v.rd);
            @(negedge clk);
            chk("rvalid", 32'({d_rvalid, if_rvalid}), (v.own == OWN_D) ? 32'd2 : 32'd1);
            erd = rd_q.pop_front();
            chk("rdata", (v.own == OWN_D) ? d_rdata : if_rdata, erd);
            tick();
            m_rvalid = 1'b0; m_rdata = $urandom;
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,   32'h0,        32'h00A00093, 0, 1, OWN_IF};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h40,  32'hDEADBEEF, 32'h0,        3, 0, OWN_D};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h44,  32'h0,        32'h12345678, 0, 0, OWN_D};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,        32'hCAFE0001, 1, 0, OWN_IF};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,        32'hCAFE0002, 0, 2, OWN_D};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h204, 32'h55AA55AA, 32'hCAFE0003, 0, 0, OWN_IF};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h204, 32'h55AA55AA, 32'h0,        2, 0, OWN_D};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h208, 32'hA5A5A5A5, 32'hCAFE0004, 0, 0, OWN_IF};

        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mreq", 32'(m_req), 32'd0);
        chk("rst_mwe", 32'(m_we), 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwdata", m_wdata, 32'd0);
        chk("rst_gnt", 32'({d_gnt, if_gnt}), 32'd0);
        chk("rst_rvalid", 32'({d_rvalid, if_rvalid}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;

        // table: fetch read, stalled write, lone data read, tie round-robin
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // reset while in RESP, then a late m_rvalid
        if_req = 1'b1; d_req = 1'b0; if_addr = 32'h80;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0; if_req = 1'b0;
        rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("rstresp_rvalid", 32'({d_rvalid, if_rvalid}), 32'd0);
        chk("rstresp_mreq", 32'(m_req), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_late_rvalid", 32'({d_rvalid, if_rvalid}), 32'd0);
        chk("idle_late_mreq", 32'(m_req), 32'd0);
        tick();
        m_rvalid = 1'b0;

        // tie right after reset: fetch first, then data
        run_vec(tbl[3]);
        run_vec(tbl[4]);

        // memory never accepts
        if_req = 1'b1; d_req = 1'b0; if_addr = 32'h300;
        tick();
        m_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (TMO) tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_mreq", 32'(m_req), 32'd0);
        chk("tmo_gnt", 32'({d_gnt, if_gnt}), 32'd0);
        repeat (10) tick();
        @(negedge clk);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        tick();
`else
        repeat (1000) tick();
        @(negedge clk);
        chk("notmo_err", 32'(err), 32'd0);
        chk("notmo_mreq", 32'(m_req), 32'd1);
        chk("notmo_gnt", 32'({d_gnt, if_gnt}), 32'd0);
        tick();
        if_req = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("final_rst_err", 32'(err), 32'd0);
        chk("final_rst_mreq", 32'(m_req), 32'd0);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
